// File: rtl/noc_flit_pkg.sv
// noc_flit_pkg: shared NoC flit layout, node constants and checker state type.
// Rev 1.0
`default_nettype none

package noc_flit_pkg;

  localparam int FLIT_W      = 20;
  localparam int NODE_ID_W   = 4;
  localparam int NUM_NODES_C = 16;

  localparam int SRC_HI  = 15;
  localparam int SRC_LO  = 12;
  localparam int DEST_HI = 7;
  localparam int DEST_LO = 4;
  localparam int PAY_HI  = 3;
  localparam int PAY_LO  = 0;

  localparam logic [FLIT_W-1:0] RSVD_HI_MASK  = 20'hF0000;
  localparam logic [FLIT_W-1:0] RSVD_MID_MASK = 20'h00F00;

  typedef logic [FLIT_W-1:0]    flit_t;
  typedef logic [NODE_ID_W-1:0] node_id_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } chk_state_e;

  function automatic logic flit_rsvd_set(input flit_t f);
    return |(f & (RSVD_HI_MASK | RSVD_MID_MASK));
  endfunction

endpackage

`default_nettype wire

// File: rtl/datain_chk_if.sv
// datain_chk_if: ejection stream, clear, capture-log read port and checker status.
// Rev 1.0
`default_nettype none

interface datain_chk_if #(
  parameter int NUM_NODES = 16,
  parameter int LOG_DEPTH = 32
) ();
  import noc_flit_pkg::*;

  localparam int AW = $clog2(LOG_DEPTH);

  logic                 clr;
  logic                 in_valid;
  logic [FLIT_W-1:0]    datain;
  logic [AW-1:0]        rd_addr;
  logic [FLIT_W-1:0]    rd_data;
  logic [AW:0]          log_count;
  logic [4:0]           good_count;
  logic [NUM_NODES-1:0] src_seen;
  logic [3:0]           err_flags;
  logic [7:0]           err_count;
  logic                 all_rcvd;

  modport master (
    output clr, in_valid, datain, rd_addr,
    input  rd_data, log_count, good_count, src_seen, err_flags, err_count, all_rcvd
  );

  modport slave (
    input  clr, in_valid, datain, rd_addr,
    output rd_data, log_count, good_count, src_seen, err_flags, err_count, all_rcvd
  );

endinterface

`default_nettype wire

// File: rtl/datain_log_ram.sv
// datain_log_ram: simple dual-port capture RAM, sync write, registered read-old-data.
// Rev 1.0
`default_nettype none

module datain_log_ram #(
  parameter int DEPTH = 32,
  parameter int W     = 20
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     i_we,
  input  wire logic [$clog2(DEPTH)-1:0] i_waddr,
  input  wire logic [W-1:0]             i_wdata,
  input  wire logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic      [W-1:0]             o_rdata
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Only the output register is reset; the array keeps its contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/datain_chk.sv
// datain_chk: NoC destination sink; classifies ejected flits, tracks sources, logs traffic.
// Rev 1.0
`default_nettype none

module datain_chk
  import noc_flit_pkg::*;
#(
  parameter int NODE_ID   = 0,
  parameter int NUM_NODES = NUM_NODES_C,
  parameter int EXPECTED  = 15,
  parameter int LOG_DEPTH = 32
) (
  input  wire logic  clk,
  input  wire logic  rst,
  datain_chk_if.slave bus
);

  localparam int               AW         = $clog2(LOG_DEPTH);
  localparam node_id_t         C_NODE_ID  = NODE_ID[NODE_ID_W-1:0];
  localparam logic [4:0]       C_EXPECTED = EXPECTED[4:0];
  localparam logic [AW:0]      C_DEPTH    = LOG_DEPTH[AW:0];

  chk_state_e           r_state;
  chk_state_e           w_state_nxt;
  logic [AW:0]          r_log_count;
  logic [4:0]           r_good_count;
  logic [NUM_NODES-1:0] r_src_seen;
  logic [3:0]           r_err_flags;
  logic [7:0]           r_err_count;
  logic                 w_all_rcvd;

  logic     w_accept;
  node_id_t w_src;
  node_id_t w_dest;
  node_id_t w_pay;
  logic     w_misroute;
  logic     w_bad_fmt;
  logic     w_dup;
  logic     w_good;
  logic     w_full;
  logic     w_we;
  logic     w_reach;

  // clr wins over a same-cycle flit: that flit is never accepted.
  assign w_accept   = bus.in_valid & ~bus.clr;
  assign w_src      = bus.datain[SRC_HI:SRC_LO];
  assign w_dest     = bus.datain[DEST_HI:DEST_LO];
  assign w_pay      = bus.datain[PAY_HI:PAY_LO];
  assign w_misroute = (w_dest != C_NODE_ID);
  assign w_bad_fmt  = flit_rsvd_set(bus.datain) | (w_pay != w_dest) | (w_src == C_NODE_ID);
  assign w_dup      = r_src_seen[w_src] & ~w_misroute & ~w_bad_fmt;
  assign w_good     = ~w_misroute & ~w_bad_fmt & ~w_dup;
  assign w_full     = (r_log_count == C_DEPTH);
  assign w_we       = w_accept & ~w_full;
  assign w_reach    = w_accept & w_good & ((r_good_count + 5'd1) == C_EXPECTED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.clr) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) w_state_nxt = w_reach ? ST_DONE : ST_RECV;
        ST_RECV: if (w_reach)  w_state_nxt = ST_DONE;
        ST_DONE: w_state_nxt = ST_DONE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_all_rcvd = (r_state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_log_count  <= '0;
      r_good_count <= '0;
      r_src_seen   <= '0;
      r_err_flags  <= '0;
      r_err_count  <= '0;
    end else if (bus.clr) begin
      r_log_count  <= '0;
      r_good_count <= '0;
      r_src_seen   <= '0;
      r_err_flags  <= '0;
      r_err_count  <= '0;
    end else if (w_accept) begin
      if (w_we) begin
        r_log_count <= r_log_count + 1'b1;
      end
      // Overflow is a logging condition only; the flit is still classified normally.
      r_err_flags <= r_err_flags | {w_full, w_dup, w_bad_fmt, w_misroute};
      if (w_good) begin
        r_src_seen[w_src] <= 1'b1;
        r_good_count      <= r_good_count + 5'd1;
      end else if (r_err_count != 8'hFF) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  datain_log_ram #(
    .DEPTH (LOG_DEPTH),
    .W     (FLIT_W)
  ) u_log_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (r_log_count[AW-1:0]),
    .i_wdata (bus.datain),
    .i_raddr (bus.rd_addr),
    .o_rdata (bus.rd_data)
  );

  assign bus.log_count  = r_log_count;
  assign bus.good_count = r_good_count;
  assign bus.src_seen   = r_src_seen;
  assign bus.err_flags  = r_err_flags;
  assign bus.err_count  = r_err_count;
  assign bus.all_rcvd   = w_all_rcvd;

endmodule

`default_nettype wire
